// File: rtl/vga_fb_pkg.sv
// Shared definitions for the frame-buffer path.
// Holds the arbiter state encoding and the default geometry constants.
// The scan-out address generator uses the same geometry constants.
package vga_fb_pkg;

    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned FB_DATA_W = 12;
    localparam int unsigned FB_DEPTH  = 76800;  // 320x240 pixel words

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLR_PEND = 2'd1,
        S_CLEAR    = 2'd2
    } fb_state_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle for vga_fb_arbiter.
// Groups the scan-out read port, the writer handshake, the clear control and the BRAM port.
//   slave  : arbiter view (the vga_fb_arbiter instance)
//   master : environment view (scan-out, writer, clear control and BRAM)
interface vga_fb_arbiter_if
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_W = FB_ADDR_W,
    parameter int unsigned DATA_W = FB_DATA_W
);
    logic              disp_rd;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              wr_starved;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_rd, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
        output disp_valid, disp_data, wr_ready, clr_busy, clr_done, wr_starved,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_rd, disp_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
        input  disp_valid, disp_data, wr_ready, clr_busy, clr_done, wr_starved,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vga_fb_clear_seq.sv
// Clear address sequencer for the frame-buffer arbiter.
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   start        : restart the sequence at address 0
//   advance      : a clear write was issued at addr this cycle
//   addr         : current clear address (stops at DEPTH-1 and never wraps)
//   at_last      : addr is DEPTH-1
//   done         : one-cycle pulse, the cycle after the last write appears on the BRAM port
module vga_fb_clear_seq #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DEPTH  = 76800
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              at_last,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q;
    logic              last_q;
    logic              done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (start) begin
                addr_q <= '0;
            end else if (advance && (addr_q != LAST_ADDR)) begin
                addr_q <= addr_q + 1'b1;
            end
            // The last write reaches the BRAM port one cycle after its slot, and done follows it.
            last_q <= advance && (addr_q == LAST_ADDR);
            done_q <= last_q;
        end
    end

    assign addr    = addr_q;
    assign at_last = (addr_q == LAST_ADDR);
    assign done    = done_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer BRAM arbiter between VGA scan-out and the result writer.
// Slot priority per cycle: display read > held write > clear write > idle.
//   clk, reset_n : pixel clock, asynchronous active-low reset
//   bus          : display read port, writer handshake (one-entry hold register),
//                  clear control and status, registered BRAM port
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned DEPTH     = FB_DEPTH,
    parameter int unsigned DATA_W    = FB_DATA_W,
    parameter int unsigned STALL_MAX = 1023
) (
    input logic             clk,
    input logic             reset_n,
    vga_fb_arbiter_if.slave bus
);
    localparam int unsigned           STALL_W   = $clog2(STALL_MAX + 1);
    localparam logic [STALL_W-1:0]    STALL_LIM = STALL_W'(STALL_MAX);

    fb_state_e         state_q, state_d;
    logic              ready_en_q;
    logic              hold_full_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_data_q;
    logic [DATA_W-1:0] clr_color_q;
    logic [STALL_W-1:0] stall_cnt_q;
    logic              rd_pend_q;
    logic              disp_valid_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              wr_accept;
    logic              clr_accept;
    logic              hold_issue;
    logic              clr_issue;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_at_last;
    logic              clr_done;

    // ready_en_q holds wr_ready low until the first edge after reset release.
    assign bus.wr_ready   = ready_en_q && !hold_full_q && (state_q == S_IDLE);
    assign bus.clr_busy   = (state_q != S_IDLE);
    assign bus.wr_starved = (stall_cnt_q == STALL_LIM);
    assign bus.clr_done   = clr_done;

    assign wr_accept  = bus.wr_valid && bus.wr_ready;
    assign clr_accept = bus.clr_start && (state_q == S_IDLE);
    assign hold_issue = hold_full_q && !bus.disp_rd;
    assign clr_issue  = (state_q == S_CLEAR) && !hold_full_q && !bus.disp_rd;

    vga_fb_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (clr_accept),
        .advance (clr_issue),
        .addr    (clr_addr),
        .at_last (clr_at_last),
        .done    (clr_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (clr_accept) state_d = hold_full_q ? S_CLR_PEND : S_CLEAR;
            S_CLR_PEND: if (hold_issue) state_d = S_CLEAR;
            S_CLEAR:    if (clr_issue && clr_at_last) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ready_en_q   <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            clr_color_q  <= '0;
            stall_cnt_q  <= '0;
            rd_pend_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;

            // wr_accept needs an empty hold, so it never coincides with hold_issue.
            if (wr_accept) begin
                hold_full_q <= 1'b1;
                hold_addr_q <= bus.wr_addr;
                hold_data_q <= bus.wr_data;
            end else if (hold_issue) begin
                hold_full_q <= 1'b0;
            end

            if (clr_accept) clr_color_q <= bus.clr_color;

            if (hold_issue) begin
                stall_cnt_q <= '0;
            end else if (hold_full_q && (stall_cnt_q != STALL_LIM)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end

            rd_pend_q    <= bus.disp_rd;
            disp_valid_q <= rd_pend_q;

            mem_en_q <= bus.disp_rd || hold_issue || clr_issue;
            mem_we_q <= hold_issue || clr_issue;
            if (bus.disp_rd) begin
                mem_addr_q <= bus.disp_addr;
            end else if (hold_issue) begin
                mem_addr_q  <= hold_addr_q;
                mem_wdata_q <= hold_data_q;
            end else if (clr_issue) begin
                mem_addr_q  <= clr_addr;
                mem_wdata_q <= clr_color_q;
            end
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.disp_valid = disp_valid_q;
    // BRAM data arrives the cycle disp_valid is high; gate it so idle cycles read as zero.
    assign bus.disp_data  = disp_valid_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a 1-cycle-latency BRAM model.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    localparam int unsigned AW   = 17;
    localparam int unsigned DW   = 12;
    localparam int unsigned DEP  = 64;
    localparam int unsigned SMAX = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_fb_arbiter #(
        .ADDR_W    (AW),
        .DEPTH     (DEP),
        .DATA_W    (DW),
        .STALL_MAX (SMAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(int i);
        return DW'((i * 37 + 5) % 4096);
    endfunction

    // BRAM model: preloaded on the first edge, then read/write on mem_en.
    logic [DW-1:0] mem_model [1024];
    bit preload_done = 1'b0;
    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 1024; i++) mem_model[i] <= pat(i);
            preload_done <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem_model[bus.mem_addr[9:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= mem_model[bus.mem_addr[9:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_rd   = 1'b0;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
    endtask

    task automatic test_reset();
        logic [AW+2*DW+7:0] outs;
        idle_inputs();
        #2 reset_n = 1'b0;
        #1;
        outs = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.disp_valid,
                bus.disp_data, bus.wr_ready, bus.clr_busy, bus.clr_done, bus.wr_starved};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", outs);
        end
        tick(); tick(); tick();
        reset_n = 1'b1;
        checks++;
        if (bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b expected 0", bus.wr_ready);
        end
        tick();
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: got %b expected 1", bus.wr_ready);
        end
    endtask

    task automatic test_display_only();
        bus.disp_rd   = 1'b1;
        bus.disp_addr = '0;
        for (int j = 1; j <= 642; j++) begin
            tick();
            if (j >= 2 && j <= 641) begin
                checks++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== pat(j - 2)) begin
                    errors++;
                    $display("FAIL disp_read[%0d]: got v=%b d=%h expected v=1 d=%h",
                             j - 2, bus.disp_valid, bus.disp_data, pat(j - 2));
                end
            end
            checks++;
            if (bus.mem_we !== 1'b0) begin
                errors++;
                $display("FAIL disp_no_write[%0d]: got mem_we=%b expected 0", j, bus.mem_we);
            end
            if (j < 640) bus.disp_addr = AW'(j);
            else         bus.disp_rd   = 1'b0;
        end
        checks++;
        if (bus.disp_valid !== 1'b0) begin
            errors++;
            $display("FAIL disp_valid_drop: got %b expected 0", bus.disp_valid);
        end
    endtask

    task automatic test_write_blanking();
        idle_inputs();
        tick();
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL blank_ready: got %b expected 1", bus.wr_ready);
        end
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 17'h00100;
        bus.wr_data  = 12'hABC;
        tick();
        bus.wr_valid = 1'b0;
        checks++;
        if (bus.mem_we !== 1'b0 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL blank_hold: got we=%b ready=%b expected we=0 ready=0",
                     bus.mem_we, bus.wr_ready);
        end
        tick();
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 17'h00100, 12'hABC}) begin
            errors++;
            $display("FAIL blank_write: got en=%b we=%b a=%h d=%h expected 1 1 00100 abc",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL blank_ready_again: got %b expected 1", bus.wr_ready);
        end
        bus.disp_rd   = 1'b1;
        bus.disp_addr = 17'h00100;
        tick();
        bus.disp_rd = 1'b0;
        tick();
        checks++;
        if (bus.disp_valid !== 1'b1 || bus.disp_data !== 12'hABC) begin
            errors++;
            $display("FAIL blank_readback: got v=%b d=%h expected v=1 d=abc",
                     bus.disp_valid, bus.disp_data);
        end
    endtask

    task automatic test_contention();
        idle_inputs();
        tick();
        checks++;
        if (bus.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL cont_ready_start: got %b expected 1", bus.wr_ready);
        end
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 17'h00050;
        bus.wr_data   = 12'h3C3;
        bus.disp_rd   = 1'b1;
        bus.disp_addr = 17'h00050;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (bus.wr_ready !== 1'b0 || bus.mem_we !== 1'b0) begin
                errors++;
                $display("FAIL cont_burst[%0d]: got ready=%b we=%b expected 0 0",
                         i, bus.wr_ready, bus.mem_we);
            end
            if (i == 2) begin
                checks++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== pat(16'h50)) begin
                    errors++;
                    $display("FAIL cont_no_forward: got v=%b d=%h expected v=1 d=%h",
                             bus.disp_valid, bus.disp_data, pat(16'h50));
                end
            end
            if (i == 15 || i == 16) begin
                checks++;
                if (bus.wr_starved !== (i == 16)) begin
                    errors++;
                    $display("FAIL cont_starved[%0d]: got %b expected %b",
                             i, bus.wr_starved, i == 16);
                end
            end
        end
        bus.disp_rd  = 1'b0;
        bus.wr_valid = 1'b0;
        tick();
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wr_starved} !== {1'b1, 17'h00050, 12'h3C3, 1'b0}) begin
            errors++;
            $display("FAIL cont_issue: got we=%b a=%h d=%h st=%b expected 1 00050 3c3 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wr_starved);
        end
    endtask

    task automatic test_clear();
        idle_inputs();
        tick();
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h0F0;
        for (int i = 1; i <= 67; i++) begin
            tick();
            bus.clr_start = 1'b0;
            if (i >= 2 && i <= 65) begin
                checks++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, AW'(i - 2), 12'h0F0}) begin
                    errors++;
                    $display("FAIL clear_write[%0d]: got we=%b a=%h d=%h expected 1 %h 0f0",
                             i - 2, bus.mem_we, bus.mem_addr, bus.mem_wdata, i - 2);
                end
            end
            if (i <= 64) begin
                checks++;
                if (bus.wr_ready !== 1'b0 || bus.clr_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL clear_busy[%0d]: got ready=%b busy=%b expected 0 1",
                             i, bus.wr_ready, bus.clr_busy);
                end
            end
            checks++;
            if (bus.clr_done !== (i == 66)) begin
                errors++;
                $display("FAIL clear_done[%0d]: got %b expected %b", i, bus.clr_done, i == 66);
            end
        end
    endtask

    task automatic test_clear_interleaved();
        int n;
        int bad;
        idle_inputs();
        tick();
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h123;
        n = 0;
        do begin
            tick();
            n++;
            bus.clr_start = 1'b0;
            bus.disp_rd   = (n == 3 || n == 10 || n == 11 || n == 20 || n == 40);
            bus.disp_addr = 17'h00200;
        end while (!bus.clr_done && n < 200);
        bus.disp_rd = 1'b0;
        checks++;
        if (n != 71) begin
            errors++;
            $display("FAIL clear_interleave_len: got %0d cycles expected 71", n);
        end
        bad = 0;
        for (int k = 0; k < 64; k++) if (mem_model[k] !== 12'h123) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_interleave_fill: got %0d wrong words expected 0", bad);
        end
    endtask

    task automatic test_clear_with_hold();
        int m;
        idle_inputs();
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 17'h00200;
        bus.wr_data  = 12'h555;
        bus.disp_rd  = 1'b1;
        tick();
        bus.wr_valid  = 1'b0;
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h00F;
        tick();
        bus.clr_start = 1'b0;
        bus.disp_rd   = 1'b0;
        checks++;
        if (dut.state_q !== S_CLR_PEND || bus.clr_busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_pend: got state=%0d busy=%b ready=%b expected 1 1 0",
                     dut.state_q, bus.clr_busy, bus.wr_ready);
        end
        tick();
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 17'h00200, 12'h555}) begin
            errors++;
            $display("FAIL hold_first: got we=%b a=%h d=%h expected 1 00200 555",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        bus.clr_start = 1'b1;
        bus.clr_color = 12'hFFF;
        tick();
        bus.clr_start = 1'b0;
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 17'h00000, 12'h00F}) begin
            errors++;
            $display("FAIL hold_clear0: got we=%b a=%h d=%h expected 1 00000 00f",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        m = 4;
        while (!bus.clr_done && m < 200) begin
            tick();
            m++;
        end
        checks++;
        if (m != 68) begin
            errors++;
            $display("FAIL hold_clear_len: got %0d expected 68", m);
        end
        tick();
        checks++;
        if (bus.clr_busy !== 1'b0 || mem_model[1] !== 12'h00F || mem_model[10'h200] !== 12'h555) begin
            errors++;
            $display("FAIL hold_restart_ignored: got busy=%b m1=%h m200=%h expected 0 00f 555",
                     bus.clr_busy, mem_model[1], mem_model[10'h200]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int seen;
        logic [AW+2*DW+7:0] outs;
        idle_inputs();
        tick();
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h777;
        n = 0;
        do begin
            tick();
            n++;
            bus.clr_start = 1'b0;
        end while (!(bus.mem_we && bus.mem_addr == 17'd30) && n < 100);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL midclr_reach30: got %0d cycles expected 32", n);
        end
        reset_n = 1'b0;
        #1;
        outs = {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.disp_valid,
                bus.disp_data, bus.wr_ready, bus.clr_busy, bus.clr_done, bus.wr_starved};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL midclr_reset_values: got %h expected 0", outs);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.clr_done) seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.clr_done || bus.clr_busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midclr_no_done: got %0d done/busy cycles expected 0", seen);
        end
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h0AA;
        tick();
        bus.clr_start = 1'b0;
        tick();
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 17'h00000, 12'h0AA}) begin
            errors++;
            $display("FAIL midclr_restart0: got we=%b a=%h d=%h expected 1 00000 0aa",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        n = 2;
        while (!bus.clr_done && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 66) begin
            errors++;
            $display("FAIL midclr_restart_len: got %0d expected 66", n);
        end
    endtask

    initial begin
        test_reset();
        test_display_only();
        test_write_blanking();
        test_contention();
        test_clear();
        test_clear_interleaved();
        test_clear_with_hold();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
